// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with valid/ready handshake on both sides.
// Optional feature macro: ID_EX_SKID_EN adds a one-entry skid buffer so
// in_ready no longer depends combinationally on out_ready.
// Payload outputs are driven from registers and read zero (NOP) when
// out_valid is low. flush and rst both empty the stage at the next edge.
module id_ex_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned OP_W   = 8,
    parameter int unsigned SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_aluop,
    input  logic [SEL_W-1:0]  in_alusel,
    input  logic [DATA_W-1:0] in_reg1,
    input  logic [DATA_W-1:0] in_reg2,
    input  logic [ADDR_W-1:0] in_wd,
    input  logic              in_wreg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_aluop,
    output logic [SEL_W-1:0]  out_alusel,
    output logic [DATA_W-1:0] out_reg1,
    output logic [DATA_W-1:0] out_reg2,
    output logic [ADDR_W-1:0] out_wd,
    output logic              out_wreg
);

    localparam int unsigned PAY_W = OP_W + SEL_W + 2 * DATA_W + ADDR_W + 1;

    logic [PAY_W-1:0] in_pay;
    logic [PAY_W-1:0] out_pay;
    logic             in_fire;
    logic             out_free;

    // Pack/unpack the payload so the storage logic handles one vector.
    assign in_pay = {in_aluop, in_alusel, in_reg1, in_reg2, in_wd, in_wreg};
    assign {out_aluop, out_alusel, out_reg1, out_reg2, out_wd, out_wreg} = out_pay;

    assign in_fire  = in_valid && in_ready;
    // Output slot can be (re)loaded this edge: empty or being consumed.
    assign out_free = !out_valid || out_ready;

`ifdef ID_EX_SKID_EN

    logic [PAY_W-1:0] skid_pay;
    logic             skid_full;

    // Ready depends only on held state, never on out_ready.
    assign in_ready = !rst && !flush && !skid_full;

    // Output register plus skid entry; skid always drains before new input.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid <= 1'b0;
            out_pay   <= PAY_W'(0);
            skid_full <= 1'b0;
            skid_pay  <= PAY_W'(0);
        end else if (out_free) begin
            if (skid_full) begin
                // in_fire cannot happen while the skid is full
                out_valid <= 1'b1;
                out_pay   <= skid_pay;
                skid_full <= 1'b0;
                skid_pay  <= PAY_W'(0);
            end else if (in_fire) begin
                out_valid <= 1'b1;
                out_pay   <= in_pay;
            end else begin
                out_valid <= 1'b0;
                out_pay   <= PAY_W'(0);
            end
        end else if (in_fire) begin
            // Output stalled: park the new instruction behind it.
            skid_full <= 1'b1;
            skid_pay  <= in_pay;
        end
    end

`else

    // Accept whenever the single output slot is free this cycle.
    assign in_ready = !rst && !flush && out_free;

    // Single output register; reload or clear whenever the slot frees up.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid <= 1'b0;
            out_pay   <= PAY_W'(0);
        end else if (out_free) begin
            if (in_fire) begin
                out_valid <= 1'b1;
                out_pay   <= in_pay;
            end else begin
                out_valid <= 1'b0;
                out_pay   <= PAY_W'(0);
            end
        end
    end

`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe, built with DATA_W=64 / ADDR_W=6.
// Reference model: an in-order queue with a capacity rule per build.
module tb_id_ex_pipe;

    typedef struct packed {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [63:0] reg1;
        logic [63:0] reg2;
        logic [5:0]  wd;
        logic        wreg;
    } pay_t;

    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready, out_valid, out_ready;
    pay_t din, dout;

    int total = 0;
    int bad   = 0;
    pay_t q[$];

    always #5 clk = ~clk;

    id_ex_pipe #(.DATA_W(64), .ADDR_W(6), .OP_W(8), .SEL_W(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_aluop(din.aluop), .in_alusel(din.alusel), .in_reg1(din.reg1),
        .in_reg2(din.reg2), .in_wd(din.wd), .in_wreg(din.wreg),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_aluop(dout.aluop), .out_alusel(dout.alusel), .out_reg1(dout.reg1),
        .out_reg2(dout.reg2), .out_wd(dout.wd), .out_wreg(dout.wreg)
    );

    // Model: may the stage take an instruction this cycle?
    function automatic bit exp_in_ready();
        if (rst || flush) return 1'b0;
`ifdef ID_EX_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || out_ready;
`endif
    endfunction

    function automatic pay_t rand_pay();
        pay_t p;
        p.aluop  = 8'($urandom);
        p.alusel = 3'($urandom);
        p.reg1   = {32'($urandom), 32'($urandom)};
        p.reg2   = {32'($urandom), 32'($urandom)};
        p.wd     = 6'($urandom);
        p.wreg   = 1'($urandom);
        return p;
    endfunction

    // Advance one clock and apply the same transfer rules to the model.
    task automatic cycle();
        bit acc, pop;
        pay_t cur;
        acc = in_valid && exp_in_ready();
        pop = (q.size() > 0) && out_ready;
        cur = din;
        @(posedge clk);
        if (rst || flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(cur);
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; din = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; din = rand_pay();
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        cycle();
        cycle();
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (dout !== pay_t'(0)) begin bad++; $display("FAIL reset_payload got=%h want=0", dout); end
        idle_inputs();
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
        cycle();
    endtask

    task automatic test_stream();
        idle_inputs();
        for (int i = 0; i <= 8; i++) begin
            in_valid = (i < 8);
            din = rand_pay();
            din.reg1 = 64'(i + 1);
            @(negedge clk);
            total++;
            if (i == 0) begin
                if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_start out_valid=%b want=0", out_valid); end
            end else if (out_valid !== 1'b1 || dout.reg1 !== 64'(i)) begin
                bad++; $display("FAIL stream_%0d out_valid=%b reg1=%0d want valid=1 reg1=%0d", i, out_valid, dout.reg1, i);
            end
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready_%0d got=%b want=1", i, in_ready); end
            cycle();
        end
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drained out_valid=%b want=0", out_valid); end
    endtask

    task automatic test_stall();
        bit skid;
`ifdef ID_EX_SKID_EN
        skid = 1'b1;
`else
        skid = 1'b0;
`endif
        idle_inputs();
        in_valid = 1'b1; din = rand_pay(); din.reg1 = 64'hA;
        cycle();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            din = rand_pay(); din.reg1 = (k == 0) ? 64'hB : 64'hC;
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || dout.reg1 !== 64'hA) begin
                bad++; $display("FAIL stall_hold_%0d valid=%b reg1=%h want valid=1 reg1=a", k, out_valid, dout.reg1);
            end
            total++;
            if (in_ready !== ((k == 0) && skid)) begin
                bad++; $display("FAIL stall_in_ready_%0d got=%b want=%b", k, in_ready, (k == 0) && skid);
            end
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || dout.reg1 !== 64'hA) begin bad++; $display("FAIL stall_release_a valid=%b reg1=%h", out_valid, dout.reg1); end
        cycle();
        @(negedge clk);
        total++;
        if (skid) begin
            if (out_valid !== 1'b1 || dout.reg1 !== 64'hB) begin bad++; $display("FAIL stall_release_b valid=%b reg1=%h want b", out_valid, dout.reg1); end
            cycle();
            @(negedge clk);
            total++;
        end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_drained out_valid=%b want=0", out_valid); end
    endtask

    task automatic test_flush();
        idle_inputs();
        out_ready = 1'b0; in_valid = 1'b1;
        din = rand_pay(); din.wreg = 1'b1; cycle();
        din = rand_pay(); din.wreg = 1'b1; cycle();
        flush = 1'b1; out_ready = 1'b1; din = rand_pay(); din.reg1 = 64'hC;
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || dout !== pay_t'(0)) begin
                bad++; $display("FAIL flush_empty_%0d valid=%b payload=%h want 0", k, out_valid, dout);
            end
            cycle();
        end
    endtask

    task automatic test_reset_stall();
        idle_inputs();
        out_ready = 1'b0; in_valid = 1'b1;
        din = rand_pay(); din.wreg = 1'b1; cycle();
        din = rand_pay(); din.wreg = 1'b1; cycle();
        rst = 1'b1; din = rand_pay(); cycle();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || dout.wreg !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_stall valid=%b wreg=%b in_ready=%b want 0/0/1", out_valid, dout.wreg, in_ready);
        end
        cycle(); cycle();
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_stall_stale out_valid=%b want=0", out_valid); end
    endtask

    task automatic test_width();
        idle_inputs();
        in_valid = 1'b1; din = rand_pay();
        din.reg2 = 64'hFFFF_0000_1234_5678; din.wd = 6'd63;
        cycle();
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_reg2_ok() == 1'b0 || dout.wd !== 6'd63) begin
            bad++; $display("FAIL width reg2=%h wd=%0d want ffff000012345678/63", dout.reg2, dout.wd);
        end
        cycle();
    endtask

    function automatic bit out_reg2_ok();
        return dout.reg2 === 64'hFFFF_0000_1234_5678;
    endfunction

    task automatic test_bubble();
        idle_inputs();
        din = rand_pay(); din.wreg = 1'b1;
        cycle();
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || dout.wreg !== 1'b0) begin
            bad++; $display("FAIL bubble valid=%b wreg=%b want 0/0", out_valid, dout.wreg);
        end
    endtask

    task automatic test_random();
        pay_t exp;
        idle_inputs();
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 63) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            din       = rand_pay();
            @(negedge clk);
            exp = (q.size() > 0) ? q[0] : pay_t'(0);
            total++;
            if (out_valid !== (q.size() > 0) || dout !== exp) begin
                bad++; $display("FAIL random_out_%0d valid=%b data=%h want valid=%b data=%h", n, out_valid, dout, q.size() > 0, exp);
            end
            total++;
            if (in_ready !== exp_in_ready()) begin
                bad++; $display("FAIL random_in_ready_%0d got=%b want=%b", n, in_ready, exp_in_ready());
            end
            cycle();
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_reset_stall();
        test_width();
        test_bubble();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
